// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   rx_state_t : receiver FSM state encoding
//   DATA_BITS  : payload bits per frame
//   bit_div()  : clocks per bit for a given clock/baud pair (truncating)
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    BREAK,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_receive_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output (2 cycles latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receive.sv
// uart_receive: 8N1 UART receiver, LSB first, idle-high line.
//   CLOCK_50  : system clock, all logic on rising edge
//   RESET_N   : synchronous active-low reset
//   RX        : asynchronous serial input
//   data      : last good byte, held until the next good byte
//   newData   : one-cycle strobe, data valid in the same cycle
//   frameErr  : one-cycle strobe when the stop bit samples low
//   parityErr : one-cycle strobe on even-parity mismatch (0 unless built
//               with UART_RX_PARITY_EN)
//   busy      : high while the receiver is not idle
// Optional feature macro: UART_RX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       RX,
  output logic [7:0] data,
  output logic       newData,
  output logic       frameErr,
  output logic       parityErr,
  output logic       busy
);

  localparam int DIV  = bit_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t              state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   rxs;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .d     (RX),
    .q     (rxs)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`else
  assign parityErr = 1'b0;
`endif

  // busy is registered alongside each state change so that it reads 0
  // straight out of reset even though the FSM parks in BREAK.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state    <= BREAK;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      data     <= '0;
      newData  <= 1'b0;
      frameErr <= 1'b0;
      busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr <= 1'b0;
      par_bad   <= 1'b0;
`endif
    end else begin
      newData  <= 1'b0;
      frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parityErr <= 1'b0;
`endif
      case (state)
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == DIV_M1) begin
            shift   <= {rxs, shift[DATA_BITS-1:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == DIV_M1) begin
            par_bad <= (rxs != ^shift);
            cnt     <= '0;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == DIV_M1) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parityErr <= 1'b1;
              end else begin
                data    <= shift;
                newData <= 1'b1;
              end
`else
              data    <= shift;
              newData <= 1'b1;
`endif
            end else begin
              frameErr <= 1'b1;
              state    <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BREAK;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
